// File: rtl/ppu_interrupt_reporter.sv
// ppu_interrupt_reporter
//   Controller for the PPU interrupt capture block. It owns the enable mask,
//   captures the triggered vector when any enabled interrupt fires, pulses
//   clear-all to re-arm capture, and then emits a 3-byte event message
//   {MSG_TAG, snapshot, seq} on a valid/ready byte stream. A holdoff period
//   after each message rate-limits the host link.
//
// Ports
//   clock               system clock, rising edge
//   reset               asynchronous, active-low reset
//   cfg_we_i/cfg_data_i enable-mask write strobe and data
//   int_enabled_o       enable mask to the capture block
//   int_triggered_i     sticky triggered vector from the capture block
//   int_any_triggered_i OR of int_triggered_i
//   int_clear_all_o     one-cycle clear pulse to the capture block
//   tx_data_o/tx_valid_o/tx_ready_i  message byte stream
//   busy_o              high whenever not IDLE
module ppu_interrupt_reporter #(
  parameter logic [7:0]  MSG_TAG   = 8'hE1,
  parameter int unsigned HOLDOFF   = 16,
  parameter int unsigned HOLDOFF_W = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cfg_we_i,
  input  logic [7:0] cfg_data_i,
  output logic [7:0] int_enabled_o,
  input  logic [7:0] int_triggered_i,
  input  logic       int_any_triggered_i,
  output logic       int_clear_all_o,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  input  logic       tx_ready_i,
  output logic       busy_o
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    TAG  = 3'd1,
    SNAP = 3'd2,
    SEQ  = 3'd3,
    HOLD = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [7:0]           enabled_q, enabled_d;
  logic [7:0]           snapshot_q, snapshot_d;
  logic [7:0]           seq_q, seq_d;
  logic [HOLDOFF_W-1:0] hold_cnt_q, hold_cnt_d;
  logic                 clear_q, clear_d;

  logic capture;
  logic handshake;

  // State register and datapath flops
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      enabled_q  <= '0;
      snapshot_q <= '0;
      seq_q      <= '0;
      hold_cnt_q <= '0;
      clear_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      enabled_q  <= enabled_d;
      snapshot_q <= snapshot_d;
      seq_q      <= seq_d;
      hold_cnt_q <= hold_cnt_d;
      clear_q    <= clear_d;
    end
  end

  // A config write in the same cycle defers capture, so the capture always
  // uses the mask that is already in effect on the following cycle.
  assign capture   = int_any_triggered_i && (enabled_q != '0) && !cfg_we_i;
  // tx_valid_o is decoded from registered state only, so tx_ready_i reaches
  // nothing but next-state logic.
  assign handshake = tx_valid_o && tx_ready_i;

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    enabled_d  = cfg_we_i ? cfg_data_i : enabled_q;
    snapshot_d = snapshot_q;
    seq_d      = seq_q;
    hold_cnt_d = hold_cnt_q;
    clear_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (capture) begin
          snapshot_d = int_triggered_i & enabled_q;
          clear_d    = 1'b1;
          state_d    = TAG;
        end
      end
      TAG: begin
        if (handshake) state_d = SNAP;
      end
      SNAP: begin
        if (handshake) state_d = SEQ;
      end
      SEQ: begin
        if (handshake) begin
          seq_d      = seq_q + 8'd1;
          hold_cnt_d = HOLDOFF_W'(HOLDOFF - 1);
          state_d    = HOLD;
        end
      end
      HOLD: begin
        // Counter loads HOLDOFF-1 at the SEQ edge; leaving on the edge that
        // sees zero gives exactly HOLDOFF cycles from that edge to IDLE.
        if (hold_cnt_q == '0) state_d = IDLE;
        else                  hold_cnt_d = hold_cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    tx_valid_o = 1'b0;
    tx_data_o  = '0;
    busy_o     = 1'b1;
    unique case (state_q)
      IDLE: busy_o = 1'b0;
      TAG: begin
        tx_valid_o = 1'b1;
        tx_data_o  = MSG_TAG;
      end
      SNAP: begin
        tx_valid_o = 1'b1;
        tx_data_o  = snapshot_q;
      end
      SEQ: begin
        tx_valid_o = 1'b1;
        tx_data_o  = seq_q;
      end
      HOLD: ;
      default: busy_o = 1'b0;
    endcase
  end

  assign int_enabled_o   = enabled_q;
  assign int_clear_all_o = clear_q;

endmodule
